ext_int_ctrl_prio: RTL and testbench
====================================

Name: ext_int_ctrl_prio

Overview:
Second-generation machine external interrupt controller on the XT high-speed bus (hb). It synchronises up to 32 raw IRQ lines and supports per-source level/rising-edge trigger, per-source priority and a global threshold. A claim/complete handshake tracks in-service sources, and it drives mextern_int / mextern_int_id into the RISC-V core.

Parameters:
INT_NUM, 32, number of sources (1..32)
PRIO_BITS, 3, priority width per source (1..4); priority 0 = never interrupts
SYNC_STAGES, 2, input synchroniser depth (1..3)
ID_BASE, 16, value added to source index to form interrupt ID

Ports:
hb_clk  in  1  sole clock
rst_sync_n  in  1  reset; one clock; reset is synchronous and active-low
xt_hb  in  hb_slave_t  bus request (waddr, wdata, raddr)
sel  in  sel_t  slave select (wen, ren)
rdata  out  32  read data
irq_source  in  INT_NUM  raw interrupt lines, asynchronous
mextern_int  out  1  external interrupt request to core
mextern_int_id  out  31  ID of current best candidate

Behaviour:
- Register map, decoded on addr[6:0]; writes take effect at the next edge:
- 0x00 ENABLE rw
- 0x04 PENDING: read; write-1-clears edge-mode bits; ignored for level bits
- 0x08 MODE rw: 1 = rising edge, 0 = level; a write clears pending for every bit whose mode changes
- 0x0C CLAIM: read = claim, write = complete
- 0x10 THRESHOLD rw, PRIO_BITS wide
- 0x40+4k PRIO word k: source 8k+j uses bits [4j+PRIO_BITS-1:4j]; unused bits read 0
- Unmapped addresses read 0; writes to them are ignored.
- Input path: SYNC_STAGES flops, then a delay flop for edge detect.
- Pending bit, level mode: equals the synced level each cycle.
- Pending bit, edge mode: set on synced 0->1; cleared by W1C or claim. Set wins over any same-cycle clear.
- Eligibility: pending & ENABLE & ~in_service & (prio > THRESHOLD).
- Arbitration: highest prio wins; ties go to lowest index.
- mextern_int and mextern_int_id are registered, updated every cycle from the arbiter.
- mextern_int_id = ID_BASE + winner index, zero-extended. When there is no winner it holds ID_BASE.
- Latency: a level source rising at edge N gives mextern_int=1 after edge N+SYNC_STAGES+2. An edge source takes the same.
- Claim read (sel.ren, raddr=0x0C):
  - rdata at the next edge = winner ID, or 0 if there is no winner.
  - Same edge: the winner's in_service bit sets and its edge pending clears.
  - mextern_int then drops on the following edge unless another source is eligible.
- Complete write: wdata[30:0] = ID.
  - If ID - ID_BASE < INT_NUM and in_service is set, that bit clears.
  - Otherwise the write is ignored.
- A claim and a complete of the same source in one cycle: complete wins (in_service ends cleared).
- Disabling a source does not clear its pending or in_service bits.
- Reads: 1-cycle latency; rdata = 0 whenever sel.ren = 0; only the CLAIM read has side effects.
- Reset (rst_sync_n=0 at an edge) clears all of the following:
  - ENABLE, MODE, THRESHOLD, all PRIO, pending, in_service, the synchronisers and the delay flop
  - mextern_int=0, mextern_int_id=0, rdata=0
- Reset mid-claim leaves no in_service bit set.

Decomposition:
- Package ext_int_pkg: register offset localparams (ENABLE/PENDING/MODE/CLAIM/THRESHOLD/PRIO_BASE) and a prio_t typedef sized by PRIO_BITS.
- Bus types come from XT_BUS.
- One sub-module, int_prio_arbiter:
  - Combinational; inputs are the eligible vector and the flattened priorities.
  - Outputs are valid, winner index and winner priority.
  - Implemented as a pairwise compare tree with ties going to the lower index.

Test Plan:
- Reset, ENABLE=0x1, PRIO0=1, level irq_source[0]=1 -> mextern_int=1 exactly 4 edges later (SYNC_STAGES=2), mextern_int_id=16; drop irq -> mextern_int=0 4 edges after the drop.
- Sources 3 (prio 2) and 5 (prio 6) both level, enabled -> id=21; claim read returns 21; id then becomes 19; complete 21 while irq5 still high -> id returns to 21.
- Equal prio 4 on sources 1 and 2 -> id=17; THRESHOLD=4 -> mextern_int=0 two edges later; THRESHOLD=3 -> mextern_int reasserts.
- MODE[7]=1, one-cycle pulse on irq7 -> PENDING reads 0x80 and stays set after the pulse; claim returns 23 and clears PENDING; a new pulse during in_service re-sets pending, with no interrupt until complete 23.
- Edge pending on source 7 plus a same-cycle W1C and new rising edge -> bit stays 1; a W1C to a level-mode bit has no effect.
- Claim with nothing eligible -> rdata=0 and no state change; complete of ID 60 or a non-in-service ID -> ignored; reset asserted mid-service -> all registers 0 and mextern_int=0.

Source files
------------

// File: rtl/ext_int_pkg.sv
// ext_int_pkg: register map and shared types of the external interrupt controller.
package ext_int_pkg;
    localparam logic [6:0] ENABLE_OFF    = 7'h00;
    localparam logic [6:0] PENDING_OFF   = 7'h04;
    localparam logic [6:0] MODE_OFF      = 7'h08;
    localparam logic [6:0] CLAIM_OFF     = 7'h0C;
    localparam logic [6:0] THRESHOLD_OFF = 7'h10;
    localparam logic [6:0] PRIO_BASE     = 7'h40;
    localparam int PRIO_BITS_DFLT = 3;
    typedef logic [PRIO_BITS_DFLT-1:0] prio_t;
    function automatic logic is_prio(input logic [6:0] a, input int nw);
        return a[6:4] == PRIO_BASE[6:4] && a[1:0] == 2'b00 && int'(a[3:2]) < nw;
    endfunction
endpackage

// File: rtl/xt_bus.sv
// xt_bus: request and select types shared by every XT high-speed bus slave.
package xt_bus;
    typedef struct packed {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
    } hb_slave_t;
    typedef struct packed {
        logic wen;
        logic ren;
    } sel_t;
endpackage

// File: rtl/int_prio_arbiter.sv
// int_prio_arbiter: pairwise compare tree picking the highest priority eligible source,
// ties resolved toward the lower index.
module int_prio_arbiter #(
    parameter int N  = 32,
    parameter int PW = 3
) (
    input  logic [N-1:0]    elig,
    input  logic [N*PW-1:0] prio_flat,
    output logic            valid,
    output logic [4:0]      idx,
    output logic [PW-1:0]   prio
);
    localparam int NP = 32;
    logic [NP-1:0]            e_pad;
    logic [NP*PW-1:0]         p_pad;
    logic [2*NP-1:1]          v;
    logic [2*NP-1:1][PW-1:0]  p;
    logic [2*NP-1:1][4:0]     ix;
    assign e_pad = NP'(elig);
    assign p_pad = (NP*PW)'(prio_flat);
    // Heap layout: leaves at NP+i, node n combines 2n (lower indices) and 2n+1.
    always_comb begin
        v  = '0;
        p  = '0;
        ix = '0;
        for (int i = 0; i < NP; i++) begin
            v[NP+i]  = e_pad[i];
            p[NP+i]  = p_pad[i*PW +: PW];
            ix[NP+i] = 5'(i);
        end
        for (int n = NP - 1; n >= 1; n--) begin
            v[n]  = v[2*n] | v[2*n+1];
            p[n]  = (v[2*n] && (!v[2*n+1] || p[2*n] >= p[2*n+1])) ? p[2*n]  : p[2*n+1];
            ix[n] = (v[2*n] && (!v[2*n+1] || p[2*n] >= p[2*n+1])) ? ix[2*n] : ix[2*n+1];
        end
    end
    assign valid = v[1];
    assign idx   = ix[1];
    assign prio  = p[1];
endmodule

// File: rtl/ext_int_ctrl_prio.sv
// ext_int_ctrl_prio: machine external interrupt controller with per-source trigger mode,
// priority, global threshold and claim/complete tracking on the XT hb bus.
module ext_int_ctrl_prio
    import ext_int_pkg::*;
    import xt_bus::*;
#(
    parameter int INT_NUM     = 32,
    parameter int PRIO_BITS   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ID_BASE     = 16
) (
    input  logic               hb_clk,
    input  logic               rst_sync_n,
    input  hb_slave_t          xt_hb,
    input  sel_t               sel,
    output logic [31:0]        rdata,
    input  logic [INT_NUM-1:0] irq_source,
    output logic               mextern_int,
    output logic [30:0]        mextern_int_id
);
    localparam int NW = (INT_NUM + 7) / 8;
    logic [SYNC_STAGES-1:0][INT_NUM-1:0] sync_q;
    logic [INT_NUM-1:0]                  dly_q, synced, rise;
    logic [INT_NUM-1:0]                  en, mode, pend, isv, elig;
    logic [INT_NUM-1:0]                  w1c, mode_chg, claim_vec, cmp_vec, pend_nxt, isv_nxt;
    logic [INT_NUM-1:0][PRIO_BITS-1:0]   prio;
    logic [PRIO_BITS-1:0]                thr, arb_prio;
    logic [6:0]                          wa, ra;
    logic [30:0]                         cidx;
    logic [31:0]                         claim_id, rd_nxt;
    logic [4:0]                          arb_idx;
    logic                                arb_valid, claim, cmp_hit, unused_bits;
    assign wa        = xt_hb.waddr[6:0];
    assign ra        = xt_hb.raddr[6:0];
    assign synced    = sync_q[SYNC_STAGES-1];
    assign rise      = synced & ~dly_q;
    assign claim     = sel.ren && ra == CLAIM_OFF && arb_valid;
    assign claim_vec = claim ? INT_NUM'(1) << arb_idx : '0;
    assign claim_id  = arb_valid ? 32'(ID_BASE) + 32'(arb_idx) : '0;
    assign cidx      = xt_hb.wdata[30:0] - 31'(ID_BASE);
    assign cmp_hit   = sel.wen && wa == CLAIM_OFF && cidx < 31'(INT_NUM);
    assign cmp_vec   = cmp_hit ? INT_NUM'(1) << cidx[4:0] : '0;
    assign w1c       = (sel.wen && wa == PENDING_OFF) ? xt_hb.wdata[INT_NUM-1:0] : '0;
    assign mode_chg  = (sel.wen && wa == MODE_OFF) ? xt_hb.wdata[INT_NUM-1:0] ^ mode : '0;
    // Edge bits: a new rising edge beats any clear in the same cycle.
    assign pend_nxt  = (mode & rise) | (mode & pend & ~(w1c | claim_vec | mode_chg))
                     | (~mode & synced & ~mode_chg);
    // Complete beats a same-cycle claim of the same source.
    assign isv_nxt   = (isv | claim_vec) & ~cmp_vec;
    assign unused_bits = ^{xt_hb.waddr[31:7], xt_hb.raddr[31:7], xt_hb.wdata[31], arb_prio};
    always_comb begin
        elig = '0;
        for (int i = 0; i < INT_NUM; i++)
            elig[i] = pend[i] & en[i] & ~isv[i] & (prio[i] > thr);
    end
    int_prio_arbiter #(.N(INT_NUM), .PW(PRIO_BITS)) u_arb (
        .elig      (elig),
        .prio_flat (prio),
        .valid     (arb_valid),
        .idx       (arb_idx),
        .prio      (arb_prio)
    );
    always_comb begin
        rd_nxt = '0;
        case (ra)
            ENABLE_OFF:    rd_nxt = 32'(en);
            PENDING_OFF:   rd_nxt = 32'(pend);
            MODE_OFF:      rd_nxt = 32'(mode);
            CLAIM_OFF:     rd_nxt = claim_id;
            THRESHOLD_OFF: rd_nxt = 32'(thr);
            default:       rd_nxt = '0;
        endcase
        for (int i = 0; i < INT_NUM; i++)
            if (is_prio(ra, NW) && int'(ra[3:2]) == i / 8)
                rd_nxt[4*(i%8) +: PRIO_BITS] = prio[i];
    end
    always_ff @(posedge hb_clk) begin
        if (!rst_sync_n) begin
            sync_q         <= '0;
            dly_q          <= '0;
            en             <= '0;
            mode           <= '0;
            thr            <= '0;
            prio           <= '0;
            pend           <= '0;
            isv            <= '0;
            rdata          <= '0;
            mextern_int    <= 1'b0;
            mextern_int_id <= '0;
        end else begin
            sync_q[0] <= irq_source;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_q[s-1];
            dly_q <= synced;
            if (sel.wen && wa == ENABLE_OFF)
                en <= xt_hb.wdata[INT_NUM-1:0];
            if (sel.wen && wa == MODE_OFF)
                mode <= xt_hb.wdata[INT_NUM-1:0];
            if (sel.wen && wa == THRESHOLD_OFF)
                thr <= xt_hb.wdata[PRIO_BITS-1:0];
            for (int i = 0; i < INT_NUM; i++)
                if (sel.wen && is_prio(wa, NW) && int'(wa[3:2]) == i / 8)
                    prio[i] <= xt_hb.wdata[4*(i%8) +: PRIO_BITS];
            pend           <= pend_nxt;
            isv            <= isv_nxt;
            rdata          <= sel.ren ? rd_nxt : '0;
            mextern_int    <= arb_valid;
            mextern_int_id <= 31'(ID_BASE) + (arb_valid ? 31'(arb_idx) : 31'd0);
        end
    end
endmodule

// File: tb/tb_ext_int_ctrl_prio.sv
// tb_ext_int_ctrl_prio: register-map vector table plus directed interrupt sequences
// with hand-computed expectations.
module tb_ext_int_ctrl_prio;
    import xt_bus::*;
    logic        hb_clk = 1'b0;
    logic        rst_sync_n = 1'b0;
    hb_slave_t   xt_hb;
    sel_t        sel;
    logic [31:0] rdata, rv;
    logic [31:0] irq_source;
    logic        mextern_int;
    logic [30:0] mextern_int_id;
    int n_cmp = 0;
    int n_err = 0;
    typedef struct {
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[9];
    always #5 hb_clk = ~hb_clk;
    ext_int_ctrl_prio #(.INT_NUM(32), .PRIO_BITS(3), .SYNC_STAGES(2), .ID_BASE(16)) dut (
        .hb_clk         (hb_clk),
        .rst_sync_n     (rst_sync_n),
        .xt_hb          (xt_hb),
        .sel            (sel),
        .rdata          (rdata),
        .irq_source     (irq_source),
        .mextern_int    (mextern_int),
        .mextern_int_id (mextern_int_id)
    );
    task automatic tick(input int n = 1);
        repeat (n) @(posedge hb_clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        xt_hb.waddr = 32'(a);
        xt_hb.wdata = d;
        sel.wen = 1'b1;
        tick();
        sel.wen = 1'b0;
    endtask
    task automatic rd(input logic [6:0] a, output logic [31:0] d);
        xt_hb.raddr = 32'(a);
        sel.ren = 1'b1;
        tick();
        sel.ren = 1'b0;
        d = rdata;
    endtask
    task automatic do_reset();
        rst_sync_n = 1'b0;
        tick(2);
        rst_sync_n = 1'b1;
    endtask
    task automatic chk_irq(input string name, input logic exp_int, input logic [30:0] exp_id);
        chk({name, "_int"}, 32'(mextern_int), 32'(exp_int));
        chk({name, "_id"}, 32'(mextern_int_id), 32'(exp_id));
    endtask
    initial begin
        xt_hb = '0;
        sel = '0;
        irq_source = '0;
        tbl[0] = '{7'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[1] = '{7'h00, 32'h5A5A_0001, 32'h5A5A_0001};
        tbl[2] = '{7'h08, 32'h0000_00A5, 32'h0000_00A5};
        tbl[3] = '{7'h10, 32'hFFFF_FFFD, 32'h0000_0005};
        tbl[4] = '{7'h40, 32'hFFFF_FFFF, 32'h7777_7777};
        tbl[5] = '{7'h4C, 32'h1234_5678, 32'h1234_5670};
        tbl[6] = '{7'h44, 32'h1111_1111, 32'h1111_1111};
        tbl[7] = '{7'h50, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[8] = '{7'h41, 32'hFFFF_FFFF, 32'h0000_0000};
        do_reset();
        chk_irq("reset", 1'b0, 31'd0);
        chk("reset_rdata", rdata, 32'd0);
        foreach (tbl[i]) begin
            wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, rv);
            chk($sformatf("reg_%02h", tbl[i].addr), rv, tbl[i].exp);
        end
        rd(7'h40, rv);
        chk("prio0_kept", rv, 32'h7777_7777);
        do_reset();
        chk("post_reset_rdata", rdata, 32'd0);
        foreach (tbl[i]) begin
            rd(tbl[i].addr, rv);
            chk($sformatf("rst_%02h", tbl[i].addr), rv, 32'd0);
        end
        // level source 0: four edges of latency each way
        wr(7'h00, 32'h1);
        wr(7'h40, 32'h1);
        irq_source[0] = 1'b1;
        tick(3);
        chk("lvl_rise_early", 32'(mextern_int), 32'd0);
        tick();
        chk_irq("lvl_rise", 1'b1, 31'd16);
        irq_source[0] = 1'b0;
        tick(3);
        chk("lvl_fall_early", 32'(mextern_int), 32'd1);
        tick();
        chk_irq("lvl_fall", 1'b0, 31'd16);
        // priority, claim and complete
        do_reset();
        wr(7'h00, 32'h28);
        wr(7'h40, 32'h0060_2000);
        irq_source[3] = 1'b1;
        irq_source[5] = 1'b1;
        tick(5);
        chk_irq("prio_pick", 1'b1, 31'd21);
        rd(7'h04, rv);
        chk("lvl_pending", rv, 32'h28);
        rd(7'h0C, rv);
        chk("claim21", rv, 32'd21);
        tick();
        chk_irq("after_claim", 1'b1, 31'd19);
        wr(7'h0C, 32'd21);
        tick();
        chk_irq("after_complete", 1'b1, 31'd21);
        // ties and threshold
        irq_source = '0;
        do_reset();
        wr(7'h00, 32'h6);
        wr(7'h40, 32'h440);
        irq_source[1] = 1'b1;
        irq_source[2] = 1'b1;
        tick(5);
        chk_irq("tie", 1'b1, 31'd17);
        wr(7'h10, 32'd4);
        chk("thr4_first", 32'(mextern_int), 32'd1);
        tick();
        chk("thr4_masked", 32'(mextern_int), 32'd0);
        wr(7'h10, 32'd3);
        chk("thr3_first", 32'(mextern_int), 32'd0);
        tick();
        chk_irq("thr3_unmask", 1'b1, 31'd17);
        // edge mode on source 7
        irq_source = '0;
        do_reset();
        wr(7'h00, 32'h80);
        wr(7'h40, 32'h5000_0000);
        wr(7'h08, 32'h80);
        irq_source[7] = 1'b1;
        tick();
        irq_source[7] = 1'b0;
        tick(4);
        rd(7'h04, rv);
        chk("edge_pend", rv, 32'h80);
        rd(7'h04, rv);
        chk("edge_pend_held", rv, 32'h80);
        chk_irq("edge_irq", 1'b1, 31'd23);
        rd(7'h0C, rv);
        chk("claim23", rv, 32'd23);
        rd(7'h04, rv);
        chk("claim_clears_pend", rv, 32'h0);
        chk("claim_drops_int", 32'(mextern_int), 32'd0);
        irq_source[7] = 1'b1;
        tick();
        irq_source[7] = 1'b0;
        tick(4);
        rd(7'h04, rv);
        chk("repend_in_service", rv, 32'h80);
        chk("masked_in_service", 32'(mextern_int), 32'd0);
        wr(7'h0C, 32'd23);
        tick();
        chk_irq("complete23", 1'b1, 31'd23);
        // W1C alone clears, but loses to a same-cycle rising edge
        wr(7'h04, 32'h80);
        rd(7'h04, rv);
        chk("w1c_clear", rv, 32'h0);
        irq_source[7] = 1'b1;
        tick();
        irq_source[7] = 1'b0;
        tick();
        wr(7'h04, 32'h80);
        rd(7'h04, rv);
        chk("w1c_vs_rise", rv, 32'h80);
        irq_source[0] = 1'b1;
        tick(4);
        wr(7'h04, 32'h1);
        rd(7'h04, rv);
        chk("w1c_level", rv, 32'h81);
        // empty claim, bad completes, claim+complete, reset mid-service
        irq_source = '0;
        do_reset();
        rd(7'h0C, rv);
        chk("empty_claim", rv, 32'd0);
        rd(7'h04, rv);
        chk("empty_claim_pend", rv, 32'd0);
        wr(7'h00, 32'h10);
        wr(7'h40, 32'h0003_0000);
        irq_source[4] = 1'b1;
        tick(5);
        chk_irq("src4", 1'b1, 31'd20);
        rd(7'h0C, rv);
        chk("claim20", rv, 32'd20);
        tick();
        chk("claim20_drop", 32'(mextern_int), 32'd0);
        wr(7'h0C, 32'd60);
        tick();
        chk("cmp60_ignored", 32'(mextern_int), 32'd0);
        wr(7'h0C, 32'd19);
        tick();
        chk("cmp19_ignored", 32'(mextern_int), 32'd0);
        wr(7'h0C, 32'd4);
        tick();
        chk("cmp4_ignored", 32'(mextern_int), 32'd0);
        wr(7'h0C, 32'd20);
        tick();
        chk("cmp20", 32'(mextern_int), 32'd1);
        xt_hb.raddr = 32'h0C;
        xt_hb.waddr = 32'h0C;
        xt_hb.wdata = 32'd20;
        sel.wen = 1'b1;
        sel.ren = 1'b1;
        tick();
        sel = '0;
        chk("claim_cmp_rdata", rdata, 32'd20);
        tick();
        chk("claim_cmp_complete_wins", 32'(mextern_int), 32'd1);
        rd(7'h0C, rv);
        chk("claim20_again", rv, 32'd20);
        do_reset();
        chk_irq("mid_reset", 1'b0, 31'd0);
        chk("mid_reset_rdata", rdata, 32'd0);
        rd(7'h00, rv);
        chk("mid_reset_en", rv, 32'd0);
        rd(7'h40, rv);
        chk("mid_reset_prio", rv, 32'd0);
        wr(7'h00, 32'h10);
        wr(7'h40, 32'h0003_0000);
        tick(4);
        chk_irq("isv_cleared_by_reset", 1'b1, 31'd20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
